// File: rtl/ddr3_wr_packer_if.sv
// Bundle of configuration, word-stream and DMA-engine signals for ddr3_wr_packer.
// slave is the packer's own view; master is the environment driving it.
interface ddr3_wr_packer_if #(
  parameter int IN_WIDTH = 64
);
  logic                  cfg_start;
  logic [26:0]           cfg_addr;
  logic [26:0]           cfg_len;
  logic [IN_WIDTH-1:0]   s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  s_last;
  logic                  write_req;
  logic [26:0]           write_start_addr;
  logic [26:0]           write_length;
  logic                  write_done;
  logic [8*IN_WIDTH-1:0] din;
  logic                  din_en;
  logic                  din_eop;
  logic                  din_rdy;
  logic                  busy;
  logic                  done;
  logic                  err_last;

  modport slave (
    input  cfg_start, cfg_addr, cfg_len, s_data, s_valid, s_last, write_done, din_rdy,
    output s_ready, write_req, write_start_addr, write_length, din, din_en, din_eop,
           busy, done, err_last
  );

  modport master (
    output cfg_start, cfg_addr, cfg_len, s_data, s_valid, s_last, write_done, din_rdy,
    input  s_ready, write_req, write_start_addr, write_length, din, din_en, din_eop,
           busy, done, err_last
  );
endinterface

// File: rtl/ddr3_wr_packer.sv
// Packs 64-bit words little-endian into 512-bit beats for a DMA write engine,
// issuing one write request per transfer and signalling completion.
module ddr3_wr_packer #(
  parameter int IN_WIDTH = 64
) (
  input logic            clk,
  input logic            rst,
  ddr3_wr_packer_if.slave bus
);
  localparam int LANES  = 8;
  localparam int BEAT_W = IN_WIDTH * LANES;

  typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT} state_t;

  state_t              state;
  logic [2:0]          lane;
  logic [29:0]         word_cnt;
  logic [26:0]         beat_cnt;
  logic                out_valid;
  logic                done_seen;
  logic [BEAT_W-1:0]   beat_q;
  logic                eop_q;
  logic                write_req_q;
  logic                done_q;
  logic                err_q;
  logic [26:0]         addr_q;
  logic [26:0]         len_q;
  logic [IN_WIDTH-1:0] pack_q [LANES-1];

  logic [29:0]       total_words;
  logic              s_ready;
  logic              accept;
  logic              din_en;
  logic [BEAT_W-1:0] next_beat;

  assign total_words = {len_q, 3'b000};
  assign din_en      = out_valid & bus.din_rdy;
  // The 8th word may only enter when the output register is free or draining now.
  assign s_ready     = (state == DATA) && (word_cnt < total_words) &&
                       !(lane == 3'd7 && out_valid && !bus.din_rdy);
  assign accept      = bus.s_valid & s_ready;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    next_beat = '0;
    for (int k = 0; k < LANES - 1; k++) next_beat[k*IN_WIDTH +: IN_WIDTH] = pack_q[k];
    next_beat[(LANES-1)*IN_WIDTH +: IN_WIDTH] = bus.s_data;
  end

  // NOTE: the staging words are always overwritten before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept && lane != 3'd7) pack_q[lane] <= bus.s_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lane        <= '0;
      word_cnt    <= '0;
      beat_cnt    <= '0;
      out_valid   <= 1'b0;
      done_seen   <= 1'b0;
      beat_q      <= '0;
      eop_q       <= 1'b0;
      write_req_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
    end else begin
      write_req_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;

      if (accept) begin
        lane     <= lane + 3'd1;
        word_cnt <= word_cnt + 30'd1;
        err_q    <= bus.s_last != (word_cnt == total_words - 30'd1);
      end

      // Loading wins over draining: a same-cycle drain frees the register for the new beat.
      if (accept && lane == 3'd7) begin
        beat_q    <= next_beat;
        eop_q     <= (word_cnt[29:3] == len_q - 27'd1);
        out_valid <= 1'b1;
      end else if (din_en) begin
        out_valid <= 1'b0;
      end

      if (din_en) beat_cnt <= beat_cnt + 27'd1;

      if (bus.write_done && (state == DATA || state == WAIT)) done_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.cfg_start) begin
            if (bus.cfg_len != '0) begin
              addr_q      <= bus.cfg_addr;
              len_q       <= bus.cfg_len;
              lane        <= '0;
              word_cnt    <= '0;
              beat_cnt    <= '0;
              done_seen   <= 1'b0;
              write_req_q <= 1'b1;
              state       <= REQ;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        REQ:  state <= DATA;
        DATA: if (din_en && eop_q) state <= WAIT;
        WAIT: begin
          if (done_seen && beat_cnt == len_q) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready          = s_ready;
  assign bus.write_req        = write_req_q;
  assign bus.write_start_addr = addr_q;
  assign bus.write_length     = len_q;
  assign bus.din              = beat_q;
  assign bus.din_en           = din_en;
  assign bus.din_eop          = out_valid & eop_q;
  assign bus.busy             = (state != IDLE);
  assign bus.done             = done_q;
  assign bus.err_last         = err_q;
endmodule

// File: tb/tb_ddr3_wr_packer.sv
// Self-checking bench for ddr3_wr_packer: table-driven and randomized transfers
// checked against a word-list model, plus zero-length and mid-transfer reset sequences.
module tb_ddr3_wr_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr3_wr_packer_if bus ();
  ddr3_wr_packer #(.IN_WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    int len;
    int rdy_mode;    // 0 always ready, 1 toggling, 2 random
    int vld_mode;    // 0 always valid, 1 random
    int bad_last;    // word index whose s_last is inverted, -1 for none
    bit early_done;  // write_done pulsed right after the request
    bit poke_start;  // cfg_start pulsed while busy
    bit seq_data;    // word i carries value i
    int exp_err;     // expected err_last pulses
  } vec_t;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_s_ready"}, bus.s_ready, 0);
    check({tag, "_write_req"}, bus.write_req, 0);
    check({tag, "_din_en"}, bus.din_en, 0);
    check({tag, "_din_eop"}, bus.din_eop, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err_last"}, bus.err_last, 0);
    check({tag, "_din"}, bus.din, 0);
    check({tag, "_addr"}, bus.write_start_addr, 0);
    check({tag, "_len"}, bus.write_length, 0);
  endtask

  // Entered and left just after a rising edge.
  task automatic run_xfer(input vec_t v);
    logic [63:0]  words[$];
    logic [511:0] exp_beats[$];
    logic [511:0] hold;
    logic [26:0]  addr;
    int total, sent, em, nreq, nerr, ndone, pending;
    bit wd_sent, poked, stall;

    total = 8 * v.len;
    for (int i = 0; i < total; i++)
      words.push_back(v.seq_data ? 64'(i) : {$urandom, $urandom});
    for (int b = 0; b < v.len; b++) begin
      logic [511:0] bt;
      for (int k = 0; k < 8; k++) bt[64*k +: 64] = words[8*b + k];
      exp_beats.push_back(bt);
    end
    addr = 27'($urandom);

    bus.cfg_addr  = addr;
    bus.cfg_len   = 27'(v.len);
    bus.cfg_start = 1'b1;
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;

    sent = 0; em = 0; nreq = 0; nerr = 0; ndone = 0;
    wd_sent = 0; poked = 0; stall = 0; hold = '0;
    for (int cyc = 0; cyc < 3000 && ndone == 0; cyc++) begin
      bus.s_valid = (v.vld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.s_data  = (sent < total) ? words[sent] : {$urandom, $urandom};
      bus.s_last  = (sent < total) ? ((sent == total - 1) ^ (sent == v.bad_last)) : 1'b0;
      case (v.rdy_mode)
        0:       bus.din_rdy = 1'b1;
        1:       bus.din_rdy = (cyc % 2 == 0);
        default: bus.din_rdy = 1'($urandom_range(0, 1));
      endcase
      bus.write_done = 1'b0;
      if (!wd_sent && (v.early_done ? (nreq > 0) : (em == v.len))) begin
        bus.write_done = 1'b1;
        wd_sent = 1;
      end
      bus.cfg_start = 1'b0;
      if (v.poke_start && !poked && sent == 3) begin
        bus.cfg_start = 1'b1;
        bus.cfg_len   = 27'd5;
        bus.cfg_addr  = ~addr;
        poked = 1;
      end

      @(negedge clk);
      pending = sent / 8 - em;
      if (bus.write_req) begin
        nreq++;
        check("req_addr", bus.write_start_addr, addr);
        check("req_len", bus.write_length, 27'(v.len));
      end
      if (stall) check("din_stable", bus.din, hold);
      stall = (pending > 0) && !bus.din_rdy;
      hold  = bus.din;
      if (bus.din_en) begin
        check("din_en_has_beat", pending > 0, 1);
        if (em < v.len) begin
          check("din", bus.din, exp_beats[em]);
          check("din_eop", bus.din_eop, em == v.len - 1);
        end else begin
          check("beat_overrun", em, v.len - 1);
        end
        em++;
      end
      if (bus.err_last) nerr++;
      if (bus.done) begin
        ndone++;
        check("done_after_last_beat", em, v.len);
        check("busy_at_done", bus.busy, 0);
      end else begin
        check("busy_in_xfer", bus.busy, 1);
      end
      if (bus.s_valid && bus.s_ready) sent++;
      @(posedge clk); #1;
    end

    bus.s_valid = 1'b0;
    bus.write_done = 1'b0;
    check("done_count", ndone, 1);
    check("write_req_count", nreq, 1);
    check("beat_count", em, v.len);
    check("words_accepted", sent, total);
    check("err_last_count", nerr, v.exp_err);
    check("addr_held", bus.write_start_addr, addr);
    check("len_held", bus.write_length, 27'(v.len));
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("busy_after", bus.busy, 0);
    @(posedge clk); #1;
  endtask

  vec_t tbl[4];

  initial begin
    rst = 1'b1;
    bus.cfg_start = 0; bus.cfg_addr = '0; bus.cfg_len = '0;
    bus.s_data = '0; bus.s_valid = 0; bus.s_last = 0;
    bus.write_done = 0; bus.din_rdy = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    tbl[0] = '{len: 1, rdy_mode: 0, vld_mode: 0, bad_last: -1, early_done: 0, poke_start: 0, seq_data: 1, exp_err: 0};
    tbl[1] = '{len: 3, rdy_mode: 1, vld_mode: 0, bad_last: -1, early_done: 0, poke_start: 0, seq_data: 0, exp_err: 0};
    tbl[2] = '{len: 2, rdy_mode: 0, vld_mode: 0, bad_last: 7,  early_done: 0, poke_start: 0, seq_data: 0, exp_err: 1};
    tbl[3] = '{len: 2, rdy_mode: 2, vld_mode: 1, bad_last: -1, early_done: 1, poke_start: 1, seq_data: 0, exp_err: 0};
    for (int i = 0; i < 4; i++) run_xfer(tbl[i]);

    // Zero-length transfer: done the next cycle, no request, never busy.
    bus.cfg_len = '0;
    bus.cfg_addr = 27'h123_4567;
    bus.cfg_start = 1'b1;
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;
    @(negedge clk);
    check("len0_done", bus.done, 1);
    check("len0_busy", bus.busy, 0);
    check("len0_write_req", bus.write_req, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("len0_done_cleared", bus.done, 0);
    check("len0_write_req_later", bus.write_req, 0);
    check("len0_busy_later", bus.busy, 0);
    @(posedge clk); #1;

    // Reset after five words of a two-beat transfer.
    begin
      int acc = 0;
      bus.cfg_len = 27'd2;
      bus.cfg_addr = 27'h0ab_cdef;
      bus.cfg_start = 1'b1;
      @(posedge clk); #1;
      bus.cfg_start = 1'b0;
      bus.din_rdy = 1'b1;
      for (int cyc = 0; cyc < 50 && acc < 5; cyc++) begin
        bus.s_valid = 1'b1;
        bus.s_data  = 64'hdead_0000 + 64'(acc);
        bus.s_last  = 1'b0;
        @(negedge clk);
        if (bus.s_valid && bus.s_ready) acc++;
        @(posedge clk); #1;
      end
      check("rst_words_fed", acc, 5);
      bus.s_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle("midrst");
      for (int cyc = 0; cyc < 5; cyc++) begin
        @(negedge clk);
        check("midrst_no_done", bus.done, 0);
      end
      @(posedge clk); #1;
    end
    run_xfer(tbl[0]);

    // Randomized transfers.
    for (int r = 0; r < 8; r++) begin
      vec_t v;
      int bad;
      v.len = $urandom_range(1, 6);
      bad = $urandom_range(0, 8 * v.len);
      v.rdy_mode   = $urandom_range(0, 2);
      v.vld_mode   = $urandom_range(0, 1);
      v.bad_last   = (bad < 8 * v.len) ? bad : -1;
      v.early_done = 1'($urandom_range(0, 1));
      v.poke_start = 1'($urandom_range(0, 1));
      v.seq_data   = 1'b0;
      v.exp_err    = (bad < 8 * v.len) ? 1 : 0;
      run_xfer(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ddr3_wr_packer.md
DDR3_WR_PACKER -- requirements
Module: ddr3_wr_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 64: input word width; fixed at 64, 8 words per 512-bit beat.
REQ-002 SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- cfg_start  in  1  one-cycle pulse that starts a transfer.
- cfg_addr  in  27  start address, passed unchanged to write_start_addr.
- cfg_len  in  27  transfer length in 512-bit beats.
- s_data  in  64  input word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid&s_ready.
- s_last  in  1  marks the final input word; used for checking only.
- write_req  out  1  one-cycle request to the DMA write engine.
- write_start_addr  out  27  latched cfg_addr.
- write_length  out  27  latched cfg_len.
- write_done  in  1  engine completion pulse.
- din  out  512  packed beat.
- din_en  out  1  beat strobe.
- din_eop  out  1  final beat of the transfer.
- din_rdy  in  1  engine can accept a beat.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err_last  out  1  one-cycle pulse on an s_last mismatch.

Function
REQ-004 SHALL implement the FSM IDLE -> REQ -> DATA -> WAIT -> IDLE.
REQ-005 IDLE: on cfg_start with cfg_len!=0, SHALL latch cfg_addr/cfg_len and go to REQ; with cfg_len==0, SHALL pulse done next cycle, issue no write_req and stay in IDLE.
REQ-006 REQ SHALL last exactly one cycle with write_req=1; write_start_addr/write_length SHALL hold the latched values from REQ until the next accepted cfg_start.
REQ-007 SHALL ignore cfg_start whenever state!=IDLE.
REQ-008 Packing SHALL be little-endian: word k of a beat (k=0..7) goes to din[64k+63:64k]. A 3-bit lane counter wraps 7->0.
REQ-009 SHALL hold one output beat register with out_valid. Accepting the 8th word SHALL load the register and set out_valid on the next edge. Latency: 8th word accepted in cycle N gives din_en no earlier than cycle N+1.
REQ-010 din_en SHALL be out_valid & din_rdy (combinational on din_rdy). din and din_eop SHALL stay stable while out_valid=1 and din_rdy=0.
REQ-011 s_ready SHALL be high only in DATA, while accepted words < 8*len, and NOT (lane==7 & out_valid & !din_rdy). This gives full throughput of 1 word/cycle with no bubble when din_rdy is held high.
REQ-012 SHALL count emitted beats in 27 bits. din_eop SHALL be 1 on the beat whose index equals len-1, and only on that beat.
REQ-013 After the final din_en, SHALL enter WAIT. A write_done seen during DATA or WAIT SHALL be latched. Leaving WAIT SHALL require the latch set and the final beat emitted; on leaving, done pulses one cycle and the FSM returns to IDLE.
REQ-014 busy SHALL be 1 in REQ, DATA and WAIT, and 0 otherwise.
REQ-015 err_last SHALL pulse the cycle after an accepted word where s_last differs from (word index == 8*len-1). Data flow SHALL NOT be altered by s_last.
REQ-016 Simultaneous din_rdy=1 draining the last beat while the 8th word is accepted SHALL load the new beat with no loss and no duplication.
REQ-017 write_done in IDLE or REQ SHALL be ignored.

Reset
REQ-018 With rst=1 at a rising edge, SHALL clear to IDLE: lane counter, beat counter, word counter, out_valid and the done latch all 0. Outputs: s_ready, write_req, din_en, din_eop, busy, done, err_last = 0; din, write_start_addr, write_length = 0.
REQ-019 Reset mid-transfer SHALL abandon the transfer; no done pulse; the partially packed beat is discarded.

Verification
REQ-020 cfg_len=1, 8 words 0..7 back-to-back, din_rdy=1 -> exactly one write_req; one din_en with din[63:0]=0 and din[511:448]=7; din_eop=1; done after write_done.
REQ-021 cfg_len=3, din_rdy toggling 1/0 each cycle -> 3 din_en; din_eop only on the 3rd; din stable during rdy=0; 24 words in order.
REQ-022 cfg_len=0 -> no write_req; done one cycle after cfg_start; busy stays 0.
REQ-023 cfg_len=2, s_last on word 7 -> err_last pulse once; all 16 words still emitted; done.
REQ-024 write_done arriving before the final beat -> latched; done asserted only after the final din_en; cfg_start issued while busy is ignored.
REQ-025 rst asserted after 5 words of cfg_len=2 -> all outputs 0 next cycle; a new transfer then completes correctly with lane 0 aligned.
